// File: rtl/fft5_pkg.sv
// Shared constants for the 8-point FFT datapath: widths, Q7 rounding and the twiddle table.
// Also provides the round-half-up / saturate helper used by the complex multiplier.
package fft5_pkg;

  localparam int SW      = 12;
  localparam int TWW     = 12;
  localparam int QSHIFT  = 7;
  localparam int ROUND_C = 64;
  localparam int FRAME   = 8;
  localparam int PW      = 24;
  localparam int SUMW    = 25;

  localparam logic signed [TWW-1:0] TW_RE [FRAME] = '{
    12'sd127, 12'sd90, 12'sd0, -12'sd90, -12'sd127, -12'sd90, 12'sd0, 12'sd90
  };
  localparam logic signed [TWW-1:0] TW_IM [FRAME] = '{
    12'sd0, -12'sd90, -12'sd127, -12'sd90, 12'sd0, 12'sd90, 12'sd127, 12'sd90
  };

  localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'((1 << (SW - 1)) - 1);
  localparam logic signed [SUMW-1:0] SAT_MIN = SUMW'(-(1 << (SW - 1)));

  // Round half up (add half an LSB, arithmetic shift), then clamp to the sample range.
  function automatic logic signed [SW-1:0] round_sat(input logic signed [SUMW-1:0] s);
    logic signed [SUMW-1:0] r;
    r = (s + SUMW'(ROUND_C)) >>> QSHIFT;
    if (r > SAT_MAX) begin
      round_sat = SAT_MAX[SW-1:0];
    end else if (r < SAT_MIN) begin
      round_sat = SAT_MIN[SW-1:0];
    end else begin
      round_sat = r[SW-1:0];
    end
  endfunction

endpackage

// File: rtl/cmul_q7_5.sv
// S2/S3 of the twiddle pipeline: four partial products, then sum, round and saturate.
// Both stages advance together on i_en; o_* are the block's output registers.
module cmul_q7_5
  import fft5_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic signed [SW-1:0]  i_a_re,
  input  logic signed [SW-1:0]  i_a_im,
  input  logic signed [TWW-1:0] i_w_re,
  input  logic signed [TWW-1:0] i_w_im,
  output logic                 o_valid,
  output logic                 o_last,
  output logic signed [SW-1:0]  o_re,
  output logic signed [SW-1:0]  o_im
);

  logic                  r_s2_valid;
  logic                  r_s2_last;
  logic signed [PW-1:0]   r_p_rr;
  logic signed [PW-1:0]   r_p_ii;
  logic signed [PW-1:0]   r_p_ri;
  logic signed [PW-1:0]   r_p_ir;
  logic signed [SUMW-1:0] w_sum_re;
  logic signed [SUMW-1:0] w_sum_im;

  assign w_sum_re = SUMW'(r_p_rr) - SUMW'(r_p_ii);
  assign w_sum_im = SUMW'(r_p_ri) + SUMW'(r_p_ir);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_p_rr     <= '0;
      r_p_ii     <= '0;
      r_p_ri     <= '0;
      r_p_ir     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_re       <= '0;
      o_im       <= '0;
    end else if (i_en) begin
      r_s2_valid <= i_valid;
      r_s2_last  <= i_last;
      r_p_rr     <= PW'(i_a_re) * PW'(i_w_re);
      r_p_ii     <= PW'(i_a_im) * PW'(i_w_im);
      r_p_ri     <= PW'(i_a_re) * PW'(i_w_im);
      r_p_ir     <= PW'(i_a_im) * PW'(i_w_re);
      o_valid    <= r_s2_valid;
      o_last     <= r_s2_last;
      o_re       <= round_sat(w_sum_re);
      o_im       <= round_sat(w_sum_im);
    end
  end

endmodule

// File: rtl/twiddle_apply_5.sv
// Streaming twiddle multiplier: sample counter, twiddle index accumulator, S1 lookup and handshake.
// Build option TWIDDLE_CONJ_EN selects conjugate twiddles (inverse-FFT direction).
module twiddle_apply_5
  import fft5_pkg::*;
#(
  parameter int unsigned STRIDE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [SW-1:0] in_re,
  input  logic signed [SW-1:0] in_im,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [SW-1:0] out_re,
  output logic signed [SW-1:0] out_im,
  output logic                out_last,
  output logic                frame_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipeline
  // moves only on advance (output register empty or being taken), so in_ready == advance.
  logic                 w_advance;
  logic                 w_accept;
  logic                 w_out_valid;
  logic [2:0]           r_k;
  logic [2:0]           r_idx;
  logic                 r_frame_err;
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic signed [SW-1:0]  r_s1_re;
  logic signed [SW-1:0]  r_s1_im;
  logic signed [TWW-1:0] r_s1_wre;
  logic signed [TWW-1:0] r_s1_wim;

  assign w_advance = !w_out_valid || out_ready;
  assign in_ready  = w_advance && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = w_out_valid;
  assign frame_err = r_frame_err;

  // A frame ends either on in_last or on wrapping past k=7; both restart k and the index at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      if (in_last || (r_k == 3'd7)) begin
        r_k   <= '0;
        r_idx <= '0;
      end else begin
        r_k   <= r_k + 3'd1;
        r_idx <= r_idx + 3'(STRIDE);
      end
      if (in_last != (r_k == 3'd7)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
      r_s1_wre   <= '0;
      r_s1_wim   <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      r_s1_last  <= in_last;
      r_s1_re    <= in_re;
      r_s1_im    <= in_im;
      r_s1_wre   <= TW_RE[r_idx];
`ifdef TWIDDLE_CONJ_EN
      r_s1_wim   <= -TW_IM[r_idx];
`else
      r_s1_wim   <= TW_IM[r_idx];
`endif
    end
  end

  cmul_q7_5 u_cmul (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_advance),
    .i_valid (r_s1_valid),
    .i_last  (r_s1_last),
    .i_a_re  (r_s1_re),
    .i_a_im  (r_s1_im),
    .i_w_re  (r_s1_wre),
    .i_w_im  (r_s1_wim),
    .o_valid (w_out_valid),
    .o_last  (out_last),
    .o_re    (out_re),
    .o_im    (out_im)
  );

endmodule

// File: doc/twiddle_apply_5.md
# twiddle_apply_5

Streaming twiddle-factor multiplier for the 8-point FFT datapath. It accepts complex samples in frames of eight, generates the twiddle index for each sample internally, and multiplies each sample by the Q7 twiddle W8^((k·STRIDE) mod 8). It then rounds and saturates the product back to 12 bits. It sits between butterfly stages, reading the same 8-entry twiddle set the butterflies use, and presents valid/ready handshakes on both sides.

## Interface
- STRIDE, 1, twiddle index step per sample (0..7); index = (k·STRIDE) mod 8, where k = sample position in frame.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_re, in_im  in  12 each  signed sample.
- in_last  in  1  marks sample k=7 of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re, out_im  out  12 each  signed product.
- out_last  out  1  in_last delayed with its sample.
- frame_err  out  1  sticky; set when in_last and the counter disagree.

## Operation
- Twiddle set (rea, img), index 0..7: (127,0) (90,-90) (0,-127) (-90,-90) (-127,0) (-90,90) (0,127) (90,90).
- Sample counter k (3 bits):
  - increments on each accepted input (in_valid && in_ready);
  - wraps 7→0;
  - forced to 0 after an accepted in_last.
- Twiddle index accumulator: 0 at frame start, +STRIDE mod 8 per accepted sample.
- Product:
  - re = a_re·w_re − a_im·w_im; im = a_re·w_im + a_im·w_re.
  - Each partial product is 24 bits signed; sums are 25 bits.
  - Rounding: add 64, then arithmetic shift right by 7 (round half up).
  - Saturate to [−2048, 2047].
- frame_err is set and held until rst in either case:
  - in_last accepted while k≠7;
  - sample accepted at k=7 without in_last.
- Counter realignment:
  - in_last at k≠7: the counter still realigns to 0.
  - k=7 without in_last: the counter wraps normally.
- Reset values: out_valid=0, out_re=0, out_im=0, out_last=0, frame_err=0, k=0, all pipeline valids=0.
- in_ready is held low while rst is high.

## Timing
- Three-stage pipeline:
  - S1: register sample, last flag and twiddle lookup.
  - S2: four partial products.
  - S3: sums, round, saturate; output register.
- Latency: 3 cycles from input acceptance to out_valid with no stall.
- Throughput: 1 sample/cycle.
- Stall control:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stages hold on !advance.
  - Bubbles are not compressed, to keep the logic simple.
- Data must not change while out_valid && !out_ready.
- Simultaneous accept-in and accept-out in the same cycle is legal and required.
- rst mid-frame: the pipeline is flushed the next cycle and in-flight samples are discarded. The first sample after reset is k=0.

## Configuration
- TWIDDLE_CONJ_EN:
  - Defined: the conjugate twiddle (rea, −img) is used for every index, giving the inverse-FFT direction.
  - Undefined: forward twiddles exactly as tabled.
- Latency and handshake are identical in both builds.

## Structure
- Shared package/header `fft5_pkg`:
  - sample width 12, twiddle width 12, Q shift 7, rounding constant 64, frame size 8;
  - twiddle re/im constant arrays.
- Sub-module `cmul_q7_5`: the pure S2/S3 datapath (products, sum, round, saturate), with enable and pipeline valid.
- Counter, index accumulator, handshake and frame_err stay in the top.

## Test plan
- STRIDE=1, k=1 sample (100,0) → out (70,−70) after 3 cycles.
- k=0 sample (1000,−500) → (992,−496).
- Saturation: k=1 sample (2047,2047) → (2047,0).
- TWIDDLE_CONJ_EN: k=2 sample (0,256):
  - undefined → (254,0);
  - defined → (−254,0).
- Backpressure: 8-sample frame with out_ready toggling 1010…:
  - no loss or duplication;
  - out_last only on the 8th output;
  - in_ready tracks advance.
- in_last on 5th sample → frame_err=1 and stays set; next sample uses index 0. rst asserted mid-frame → out_valid=0 next cycle; frame_err=0.
